// File: rtl/sticky_arb_pkg.sv
// sticky_arb_pkg: shared state and grant-end-cause encodings for the sticky request arbiter
package sticky_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
  typedef enum logic [1:0] {REL, TMO, VIOL} end_cause_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select of the first set request after ptr, wrapping
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  oh_o,
  output logic [IW-1:0] id_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  always_comb begin
    oh_o = '0;
    id_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (req_i[j]) begin
        oh_o = N'(1) << j;
        id_o = j;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sticky_req_arbiter.sv
// sticky_req_arbiter: round-robin arbiter enforcing held requests, with violation flags and hold timeout
module sticky_req_arbiter
  import sticky_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int HOLD_MAX = 32,
  parameter int CNT_W = $clog2(HOLD_MAX + 1),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_id_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   hold_cnt_o,
  output logic [NUM_REQ-1:0] viol_o,
  output logic               timeout_o
);
  state_e state_q, state_d;
  end_cause_e cause;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, viol_q, viol_d, pend_q, pend_d, elig, pick_oh;
  logic [IW-1:0] gnt_id_q, gnt_id_d, ptr_q, ptr_d, pick_id;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic timeout_q, timeout_d, pick_any, start, in_grant, grant_end;
  assign elig = req_i & ~viol_q;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i(elig),
    .ptr_i(ptr_q),
    .oh_o(pick_oh),
    .id_o(pick_id),
    .any_o(pick_any)
  );
  assign start = (state_q == IDLE) & pick_any;
  assign in_grant = state_q == GRANT;
  assign cause = !req_i[gnt_id_q] ? VIOL : release_i ? REL : TMO;
  assign grant_end = in_grant & (!req_i[gnt_id_q] | release_i | (hold_cnt_q == CNT_W'(HOLD_MAX)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (pick_any ? GRANT : IDLE) :
              (state_q == GRANT) ? (grant_end ? GAP : GRANT) : IDLE;
  end
  always_comb begin
    gnt_d = start ? pick_oh : grant_end ? '0 : gnt_q;
    gnt_id_d = start ? pick_id : gnt_id_q;
    ptr_d = start ? pick_id : ptr_q;
    hold_cnt_d = start ? CNT_W'(1) : (in_grant & ~grant_end) ? hold_cnt_q + CNT_W'(1) : '0;
    timeout_d = grant_end & (cause == TMO);
    pend_d = req_i & ~gnt_q & ~(start ? pick_oh : '0);
    viol_d = viol_q | (pend_q & ~req_i) | ((grant_end & (cause == VIOL)) ? gnt_q : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      gnt_id_q <= '0;
      ptr_q <= IW'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      timeout_q <= 1'b0;
      pend_q <= '0;
      viol_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q <= timeout_d;
      pend_q <= pend_d;
      viol_q <= viol_d;
    end
  end
  assign gnt_o = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign busy_o = in_grant;
  assign hold_cnt_o = hold_cnt_q;
  assign viol_o = viol_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_sticky_req_arbiter.sv
// tb_sticky_req_arbiter: directed and random stimulus checked against a behavioural arbiter model
module tb_sticky_req_arbiter;
  localparam int N = 4;
  localparam int HM = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_i = '0;
  logic release_i = 1'b0;
  logic [N-1:0] gnt_o, viol_o;
  logic [1:0] gnt_id_o;
  logic busy_o, timeout_o;
  logic [5:0] hold_cnt_o;
  int n_chk = 0;
  int n_fail = 0;
  bit m_busy, m_gap, m_tmo;
  int m_holder, m_held, m_ptr;
  bit [N-1:0] m_viol, m_wait;
  sticky_req_arbiter #(.NUM_REQ(N), .HOLD_MAX(HM)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req_i),
    .release_i(release_i),
    .gnt_o(gnt_o),
    .gnt_id_o(gnt_id_o),
    .busy_o(busy_o),
    .hold_cnt_o(hold_cnt_o),
    .viol_o(viol_o),
    .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));
  a_held: assert property (@(posedge clk) disable iff (!rst_n)
    (busy_o && !req_i[gnt_id_o]) |=> (!busy_o && viol_o[$past(gnt_id_o)]));
  function automatic void model_reset();
    m_busy = 0;
    m_gap = 0;
    m_tmo = 0;
    m_holder = 0;
    m_held = 0;
    m_ptr = N - 1;
    m_viol = '0;
    m_wait = '0;
  endfunction
  function automatic void model_step(bit [N-1:0] r, bit rel);
    bit was_busy = m_busy;
    int was_holder = m_holder;
    int pick = -1;
    bit fin = 0;
    bit [N-1:0] old_viol = m_viol;
    m_tmo = 0;
    for (int j = 0; j < N; j++) if (m_wait[j] && !r[j]) m_viol[j] = 1;
    if (m_busy) begin
      if (!r[m_holder]) begin
        m_viol[m_holder] = 1;
        fin = 1;
      end else if (rel) fin = 1;
      else if (m_held == HM) begin
        m_tmo = 1;
        fin = 1;
      end
      if (fin) begin
        m_busy = 0;
        m_gap = 1;
        m_held = 0;
      end else m_held++;
    end else if (m_gap) m_gap = 0;
    else begin
      for (int k = 1; k <= N; k++) begin
        int j = (m_ptr + k) % N;
        if (pick < 0 && r[j] && !old_viol[j]) pick = j;
      end
      if (pick >= 0) begin
        m_busy = 1;
        m_holder = pick;
        m_ptr = pick;
        m_held = 1;
      end
    end
    for (int j = 0; j < N; j++) m_wait[j] = r[j] && !(was_busy && was_holder == j) && (j != pick);
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    check("gnt_o", 32'(gnt_o), m_busy ? (32'd1 << m_holder) : 32'd0);
    check("gnt_id_o", 32'(gnt_id_o), 32'(m_holder));
    check("busy_o", 32'(busy_o), 32'(m_busy));
    check("hold_cnt_o", 32'(hold_cnt_o), 32'(m_held));
    check("viol_o", 32'(viol_o), 32'(m_viol));
    check("timeout_o", 32'(timeout_o), 32'(m_tmo));
  endtask
  task automatic cyc();
    model_step(req_i, release_i);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    req_i = '0;
    release_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask
  task automatic wait_busy();
    for (int i = 0; i < 20 && busy_o !== 1'b1; i++) cyc();
    check("wait_busy", 32'(busy_o), 32'd1);
  endtask
  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int tmo_cnt;
    bit [N-1:0] r;
    do_reset();
    req_i = 4'b0001;
    cyc();
    check("t1_gnt", 32'(gnt_o), 32'h1);
    for (int i = 0; i < 10 && hold_cnt_o != 6'd5; i++) cyc();
    check("t1_hold5", 32'(hold_cnt_o), 32'd5);
    release_i = 1'b1;
    cyc();
    release_i = 1'b0;
    check("t1_end", 32'(busy_o), 32'd0);
    req_i = '0;
    cyc();
    cyc();
    check("t1_noviol", 32'(viol_o), 32'd0);
    do_reset();
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_busy();
      check("t2_order", 32'(gnt_id_o), 32'(exp_order[g]));
      cyc();
      release_i = 1'b1;
      cyc();
      release_i = 1'b0;
      check("t2_gap", 32'(busy_o), 32'd0);
    end
    do_reset();
    req_i = 4'b0101;
    cyc();
    check("t3_gnt0", 32'(gnt_o), 32'h1);
    cyc();
    req_i = 4'b0001;
    cyc();
    check("t3_viol", 32'(viol_o), 32'h4);
    release_i = 1'b1;
    cyc();
    release_i = 1'b0;
    req_i = 4'b0100;
    for (int i = 0; i < 8; i++) cyc();
    check("t3_masked", 32'(gnt_o), 32'h0);
    do_reset();
    req_i = 4'b1010;
    cyc();
    cyc();
    cyc();
    check("t4_hold3", 32'(hold_cnt_o), 32'd3);
    req_i = 4'b1000;
    cyc();
    check("t4_viol", 32'(viol_o), 32'h2);
    check("t4_gnt0", 32'(gnt_o), 32'h0);
    cyc();
    cyc();
    check("t4_next", 32'(gnt_id_o), 32'd3);
    release_i = 1'b1;
    cyc();
    release_i = 1'b0;
    do_reset();
    req_i = 4'b0001;
    tmo_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      tmo_cnt += int'(timeout_o);
    end
    check("t5_tmo_once", 32'(tmo_cnt), 32'd1);
    check("t5_noviol", 32'(viol_o), 32'd0);
    do_reset();
    req_i = 4'b0010;
    cyc();
    req_i = 4'b0001;
    cyc();
    cyc();
    cyc();
    for (int i = 0; i < 6; i++) cyc();
    check("t6_hold7", 32'(hold_cnt_o), 32'd7);
    check("t6_viol", 32'(viol_o), 32'h2);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    req_i = 4'b0011;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
    check("t6_first", 32'(gnt_id_o), 32'd0);
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        r = req_i;
        for (int j = 0; j < N; j++)
          r[j] = r[j] ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
        req_i = r;
        release_i = $urandom_range(0, 3) == 0;
        cyc();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
